// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// stalls the front of the pipeline while busy and holds LO/HI while the pipeline is held.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             pipe_hold,
    input  logic             div_cancel,
    output logic             div_stall,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] qraw_s;
    logic [WIDTH-1:0] rraw_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sg);
        logic [WIDTH-1:0] r;
        if (sg && v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        logic [WIDTH-1:0] r;
        if (n) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Trial subtraction; the partial remainder is always below the divisor, so its
    // 33rd bit is zero before the shift and only the low WIDTH bits are stored.
    always_comb begin
        shifted_s = {rem_q, dvd_q[WIDTH-1]};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvs_q};
        borrow_s  = diff_s[WIDTH+1];
        qraw_s    = {dvd_q[WIDTH-2:0], ~borrow_s};
        if (borrow_s) begin
            rraw_s = shifted_s[WIDTH-1:0];
        end else begin
            rraw_s = diff_s[WIDTH-1:0];
        end
    end

    // Next-state, datapath next values and combinational handshake outputs
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        cnt_d     = cnt_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        div_stall = 1'b0;
        div_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (div_cancel) begin
                    state_d = ST_IDLE;
                end else if (div_start) begin
                    div_stall = 1'b1;
                    dvd_d     = abs_val(opa, div_signed);
                    dvs_d     = abs_val(opb, div_signed);
                    negq_d    = div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    negr_d    = div_signed & opa[WIDTH-1];
                    rem_d     = {WIDTH{1'b0}};
                    cnt_d     = 6'd0;
                    state_d   = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (div_cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    div_stall = 1'b1;
                    dvd_d     = qraw_s;
                    rem_d     = rraw_s;
                    cnt_d     = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH - 1)) begin
                        // Sign fix lands in the output registers on entry to DONE
                        quo_d   = neg_if(qraw_s, negq_q);
                        rmd_d   = neg_if(rraw_s, negr_q);
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                if (div_cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    div_ready = 1'b1;
                    if (pipe_hold) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            dvd_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rmd_q   <= {WIDTH{1'b0}};
            cnt_q   <= 6'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected LO/HI pushed at start, popped when div_ready rises.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        pipe_hold;
    logic        div_cancel;
    logic        div_stall;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .opa        (opa),
        .opb        (opb),
        .pipe_hold  (pipe_hold),
        .div_cancel (div_cancel),
        .div_stall  (div_stall),
        .div_ready  (div_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; drives a divide and checks timing and results.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int hold);
        int   stalls;
        int   early;
        exp_t e;
        sb_q.push_back('{q: eq, r: er});
        div_start  = 1'b1;
        div_signed = sg;
        opa        = a;
        opb        = b;
        #1;
        stalls = 0;
        early  = 0;
        while (div_stall && stalls < 100) begin
            stalls++;
            if (div_ready) early++;
            @(posedge clk); #1;
        end
        check_val("stall_len", stalls, 32'd33);
        check_val("ready_early", early, 32'd0);
        check_val("ready", {31'd0, div_ready}, 32'd1);
        if (div_ready) begin
            e = sb_q.pop_front();
            check_val("quotient", quotient, e.q);
            check_val("remainder", remainder, e.r);
            pipe_hold = (hold > 0);
            for (int i = 1; i <= hold; i++) begin
                @(posedge clk); #1;
                if (i == hold) pipe_hold = 1'b0;
                check_val("hold_ready", {31'd0, div_ready}, 32'd1);
                check_val("hold_stall", {31'd0, div_stall}, 32'd0);
                check_val("hold_q", quotient, e.q);
                check_val("hold_r", remainder, e.r);
            end
        end
        @(posedge clk); #1;
        div_start = 1'b0;
        pipe_hold = 1'b0;
        #1;
        check_val("post_ready", {31'd0, div_ready}, 32'd0);
        check_val("post_stall", {31'd0, div_stall}, 32'd0);
    endtask

    initial begin
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic        [31:0] ra;
        logic        [31:0] rb;
        logic        [31:0] mq;
        logic        [31:0] mr;
        int                 nready;

        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        opa        = 32'd0;
        opb        = 32'd0;
        pipe_hold  = 1'b0;
        div_cancel = 1'b0;
        #12;
        check_val("rst_stall", {31'd0, div_stall}, 32'd0);
        check_val("rst_ready", {31'd0, div_ready}, 32'd0);
        check_val("rst_q", quotient, 32'd0);
        check_val("rst_r", remainder, 32'd0);
        #4 resetn = 1'b1;
        @(posedge clk); #1;

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
        run_div(1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_div(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 5);

        // Random operands checked against the language's own division
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd3;
            if (k[0]) begin
                sa = ra;
                sb = rb;
                if (k == 3) sb = -sb;
                if (sa == 32'sh8000_0000 && sb == -32'sd1) sb = 32'sd3;
                mq = sa / sb;
                mr = sa % sb;
                run_div(1'b1, sa, sb, mq, mr, 0);
            end else begin
                mq = ra / rb;
                mr = ra % rb;
                run_div(1'b0, ra, rb, mq, mr, 0);
            end
        end

        // Cancel at BUSY cycle 10
        div_start  = 1'b1;
        div_signed = 1'b0;
        opa        = 32'd5000;
        opb        = 32'd9;
        repeat (10) begin @(posedge clk); #1; end
        div_cancel = 1'b1;
        #1;
        check_val("cancel_stall", {31'd0, div_stall}, 32'd0);
        @(posedge clk); #1;
        div_cancel = 1'b0;
        div_start  = 1'b0;
        #1;
        check_val("cancel_idle", {31'd0, div_stall}, 32'd0);
        nready = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_ready) nready++;
        end
        check_val("cancel_noready", nready, 32'd0);
        run_div(1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 0);

        // Asynchronous reset at BUSY cycle 20
        div_start = 1'b1;
        opa       = 32'hDEAD_BEEF;
        opb       = 32'd77;
        repeat (20) begin @(posedge clk); #1; end
        #1;
        check_val("pre_rst_stall", {31'd0, div_stall}, 32'd1);
        div_start = 1'b0;
        resetn    = 1'b0;
        #1;
        check_val("arst_stall", {31'd0, div_stall}, 32'd0);
        check_val("arst_ready", {31'd0, div_ready}, 32'd0);
        check_val("arst_q", quotient, 32'd0);
        check_val("arst_r", remainder, 32'd0);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0);

        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
